riscv_i32_dmem_target: RTL and testbench

- Memory-side responder for the RISC-V i32 data-memory access interface.
- Accepts the access request the core issues each cycle: address, byte enable, read/write enable and pre-rotated write data.
- Inserts a parameterised number of wait states, then drives a single-ported synchronous SRAM (1-cycle read latency). Returns the raw 32-bit word with a valid strobe.
- Sits between the core's dmem request path and the tightly-coupled data SRAM; flags out-of-window accesses as errors.

---
 rtl/riscv_i32_dmem_target_pkg.sv | 42 ++++
 rtl/riscv_i32_dmem_wait_counter.sv | 44 ++++
 rtl/riscv_i32_dmem_target.sv | 160 ++++++++++++++++
 tb/tb_riscv_i32_dmem_target.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_i32_dmem_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_i32_dmem_types (package)
// Brief    : Shared types and constants for the i32 data-memory target.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_i32_dmem_types;

  localparam int DMEM_MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAITING   = 2'd1,
    READ_RESP = 2'd2
  } dmem_target_state;

  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] write_data;
  } dmem_access_req_t;

  typedef struct packed {
    logic        stall;
    logic        read_data_valid;
    logic [31:0] read_data;
    logic        access_error;
  } dmem_access_resp_t;

  // Window size is 4 * 2^addr_bits bytes; base must be aligned to it.
  function automatic logic dmem_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int          addr_bits);
    logic [31:0] mask;
    mask = (32'd4 << addr_bits) - 32'd1;
    return (addr & ~mask) == base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_i32_dmem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_i32_dmem_wait_counter
// Brief    : 4-bit wait-state counter: load, saturating decrement, clear.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_i32_dmem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] load_value_i,
  input  logic       decrement_i,
  output logic [3:0] count_o,
  output logic       zero_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 4'd0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (decrement_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/riscv_i32_dmem_target.sv
`default_nettype none
// ============================================================================
// Module   : riscv_i32_dmem_target
// Brief    : Data-memory responder: wait states, window decode, SRAM drive.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_i32_dmem_target
  import riscv_i32_dmem_types::*;
#(
  parameter int          ADDR_BITS    = 12,
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int          WAIT_STATES  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          dmem_access_req__address,
  input  logic [3:0]           dmem_access_req__byte_enable,
  input  logic                 dmem_access_req__write_enable,
  input  logic                 dmem_access_req__read_enable,
  input  logic [31:0]          dmem_access_req__write_data,
  output logic                 dmem_access_resp__wait,
  output logic                 dmem_access_resp__read_data_valid,
  output logic [31:0]          dmem_access_resp__read_data,
  output logic                 dmem_access_resp__access_error,
  output logic                 sram_select,
  output logic [ADDR_BITS-1:0] sram_address,
  output logic                 sram_write_enable,
  output logic [3:0]           sram_byte_enable,
  output logic [31:0]          sram_write_data,
  input  logic [31:0]          sram_read_data
);

  // Out-of-range settings saturate at the counter's capacity.
  localparam int c_WS = (WAIT_STATES > DMEM_MAX_WAIT_STATES) ? DMEM_MAX_WAIT_STATES :
                        (WAIT_STATES < 0) ? 0 : WAIT_STATES;
  localparam logic [3:0] c_LOAD_VALUE = (c_WS > 0) ? 4'(c_WS - 1) : 4'd0;

  dmem_access_req_t  w_req;
  dmem_access_resp_t w_resp;
  dmem_target_state  state_q;
  dmem_target_state  state_d;

  logic       w_present;
  logic       w_is_read;
  logic       w_is_write;
  logic       w_in_window;
  logic       w_stall;
  logic       w_complete;
  logic       w_cnt_load;
  logic       w_cnt_dec;
  logic       w_cnt_clear;
  logic       w_cnt_zero;
  logic [3:0] w_cnt_value;

  logic valid_q;
  logic error_q;
  logic read_error_q;

  assign w_req = '{
    address:      dmem_access_req__address,
    byte_enable:  dmem_access_req__byte_enable,
    write_enable: dmem_access_req__write_enable,
    read_enable:  dmem_access_req__read_enable,
    write_data:   dmem_access_req__write_data
  };

  assign w_present   = w_req.read_enable | w_req.write_enable;
  assign w_is_read   = w_req.read_enable;
  assign w_is_write  = w_req.write_enable & ~w_req.read_enable;
  assign w_in_window = dmem_in_window(w_req.address, BASE_ADDRESS, ADDR_BITS);

  riscv_i32_dmem_wait_counter u_wait_counter (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (w_cnt_clear),
    .load_i       (w_cnt_load),
    .load_value_i (c_LOAD_VALUE),
    .decrement_i  (w_cnt_dec),
    .count_o      (w_cnt_value),
    .zero_o       (w_cnt_zero)
  );

  always_comb begin
    state_d     = IDLE;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_clear = 1'b0;
    case (state_q)
      IDLE, READ_RESP: begin
        if (w_present) begin
          if (c_WS == 0) begin
            w_complete = 1'b1;
          end else begin
            w_stall    = 1'b1;
            w_cnt_load = 1'b1;
            state_d    = WAITING;
          end
        end
      end
      WAITING: begin
        if (!w_present) begin
          w_cnt_clear = 1'b1;
        end else if (!w_cnt_zero) begin
          w_stall   = 1'b1;
          w_cnt_dec = 1'b1;
          state_d   = WAITING;
        end else begin
          w_complete = 1'b1;
        end
      end
      default: begin
        w_cnt_clear = 1'b1;
      end
    endcase
    if (w_complete) begin
      state_d = w_is_read ? READ_RESP : IDLE;
    end
    // The combinational request path is silenced for the whole reset window.
    if (reset) begin
      w_stall    = 1'b0;
      w_complete = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      read_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= w_complete & w_is_read;
      error_q      <= w_complete & ~w_in_window;
      read_error_q <= w_complete & w_is_read & ~w_in_window;
    end
  end

  assign w_resp = '{
    stall:           w_stall,
    read_data_valid: valid_q,
    read_data:       (valid_q && !read_error_q) ? sram_read_data : 32'h0,
    access_error:    error_q
  };

  assign dmem_access_resp__wait            = w_resp.stall;
  assign dmem_access_resp__read_data_valid = w_resp.read_data_valid;
  assign dmem_access_resp__read_data       = w_resp.read_data;
  assign dmem_access_resp__access_error    = w_resp.access_error;

  assign sram_select       = w_complete & w_in_window;
  assign sram_write_enable = w_complete & w_in_window & w_is_write;
  assign sram_byte_enable  = sram_select ? w_req.byte_enable : 4'h0;
  assign sram_address      = w_req.address[ADDR_BITS+1:2];
  assign sram_write_data   = w_req.write_data;

endmodule
`default_nettype wire

// File: tb/tb_riscv_i32_dmem_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_i32_dmem_target
// Brief    : Self-checking bench: WS=0 and WS=3 instances, each with an SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_i32_dmem_target;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset;
  logic preload;
  always #5 clk = ~clk;

  logic [31:0] req_addr [2];
  logic [3:0]  req_be   [2];
  logic        req_we   [2];
  logic        req_re   [2];
  logic [31:0] req_wd   [2];
  logic        rsp_wait [2];
  logic        rsp_valid[2];
  logic [31:0] rsp_rdata[2];
  logic        rsp_err  [2];
  logic        s_sel    [2];
  logic [11:0] s_addr   [2];
  logic        s_we     [2];
  logic [3:0]  s_be     [2];
  logic [31:0] s_wdata  [2];
  logic [31:0] s_rdata  [2];

  riscv_i32_dmem_target #(.ADDR_BITS(12), .BASE_ADDRESS(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .dmem_access_req__address(req_addr[0]), .dmem_access_req__byte_enable(req_be[0]),
    .dmem_access_req__write_enable(req_we[0]), .dmem_access_req__read_enable(req_re[0]),
    .dmem_access_req__write_data(req_wd[0]),
    .dmem_access_resp__wait(rsp_wait[0]), .dmem_access_resp__read_data_valid(rsp_valid[0]),
    .dmem_access_resp__read_data(rsp_rdata[0]), .dmem_access_resp__access_error(rsp_err[0]),
    .sram_select(s_sel[0]), .sram_address(s_addr[0]), .sram_write_enable(s_we[0]),
    .sram_byte_enable(s_be[0]), .sram_write_data(s_wdata[0]), .sram_read_data(s_rdata[0])
  );

  riscv_i32_dmem_target #(.ADDR_BITS(12), .BASE_ADDRESS(32'h0), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .dmem_access_req__address(req_addr[1]), .dmem_access_req__byte_enable(req_be[1]),
    .dmem_access_req__write_enable(req_we[1]), .dmem_access_req__read_enable(req_re[1]),
    .dmem_access_req__write_data(req_wd[1]),
    .dmem_access_resp__wait(rsp_wait[1]), .dmem_access_resp__read_data_valid(rsp_valid[1]),
    .dmem_access_resp__read_data(rsp_rdata[1]), .dmem_access_resp__access_error(rsp_err[1]),
    .sram_select(s_sel[1]), .sram_address(s_addr[1]), .sram_write_enable(s_we[1]),
    .sram_byte_enable(s_be[1]), .sram_write_data(s_wdata[1]), .sram_read_data(s_rdata[1])
  );

  function automatic logic [31:0] pattern(input int i);
    return 32'(i * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  // SRAM environment: 1-cycle read latency, output holds between reads.
  logic [31:0] sram_mem [2][DEPTH];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (preload) begin
        for (int i = 0; i < DEPTH; i++) sram_mem[g][i] <= pattern(i);
      end else if (s_sel[g]) begin
        if (s_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (s_be[g][b]) sram_mem[g][s_addr[g]][8*b +: 8] <= s_wdata[g][8*b +: 8];
        end else begin
          s_rdata[g] <= sram_mem[g][s_addr[g]];
        end
      end
    end
  end

  // Reference model: byte-addressed view of each window.
  logic [31:0] exp_mem [2][DEPTH];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_req(input int s);
    req_addr[s] = 32'h0; req_be[s] = 4'h0; req_we[s] = 1'b0;
    req_re[s] = 1'b0; req_wd[s] = 32'h0;
  endtask

  task automatic do_access(input int s, input logic [31:0] addr, input logic [3:0] be,
                           input logic we, input logic re, input logic [31:0] wd,
                           input logic esel, input logic eswe, input logic evalid,
                           input logic eerr, input logic [31:0] erd);
    int  waits;
    bit  done;
    waits = 0;
    done  = 1'b0;
    @(posedge clk); #1;
    req_addr[s] = addr; req_be[s] = be; req_we[s] = we; req_re[s] = re; req_wd[s] = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (rsp_wait[s]) begin
        waits++;
        check("select_while_waiting", s_sel[s], 1'b0);
      end else begin
        done = 1'b1;
        check("wait_cycles", waits, ws_of(s));
        check("sram_select", s_sel[s], esel);
        if (esel) begin
          check("sram_address", s_addr[s], 12'((addr >> 2) % DEPTH));
          check("sram_write_enable", s_we[s], eswe);
          check("sram_byte_enable", s_be[s], be);
          if (eswe) check("sram_write_data", s_wdata[s], wd);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: wait still %0d after 40 cycles, required 0", rsp_wait[s]);
    end
    @(posedge clk); #1;
    idle_req(s);
    @(negedge clk);
    check("read_data_valid", rsp_valid[s], evalid);
    check("access_error", rsp_err[s], eerr);
    check("read_data", rsp_rdata[s], erd);
    @(negedge clk);
    check("valid_after_resp", rsp_valid[s], 1'b0);
    check("error_after_resp", rsp_err[s], 1'b0);
    if (we && !re && addr < 32'h4000) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) exp_mem[s][(addr >> 2) % DEPTH][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  typedef struct {
    int          s;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic        re;
    logic [31:0] wd;
    logic        esel;
    logic        eswe;
    logic        evalid;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{0, 32'h10,   4'hF, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{0, 32'h10,   4'hF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{0, 32'h4000, 4'hF, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1, 32'h102,  4'h4, 1'b1, 1'b0, 32'h00AB0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1, 32'h100,  4'hF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hE5AB4040};
    vecs[5]  = '{1, 32'h24,   4'hF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hACAC0909};
    vecs[6]  = '{1, 32'h4010, 4'hF, 1'b1, 1'b0, 32'h11112222, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{0, 32'h10,   4'hF, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[8]  = '{0, 32'h10,   4'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{0, 32'h10,   4'hF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{1, 32'h10,   4'hF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hA1A10404};
    vecs[11] = '{1, 32'h4000, 4'hF, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0};

    for (int g = 0; g < 2; g++) begin
      idle_req(g);
      s_rdata[g] = 32'h0;
      for (int i = 0; i < DEPTH; i++) exp_mem[g][i] = pattern(i);
    end

    // Reset with requests pending: everything must stay quiet.
    reset = 1'b1;
    preload = 1'b1;
    req_re[0] = 1'b1;
    req_re[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check("reset_wait", rsp_wait[g], 1'b0);
      check("reset_valid", rsp_valid[g], 1'b0);
      check("reset_rdata", rsp_rdata[g], 32'h0);
      check("reset_error", rsp_err[g], 1'b0);
      check("reset_select", s_sel[g], 1'b0);
      check("reset_sram_we", s_we[g], 1'b0);
      idle_req(g);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 12; v++)
      do_access(vecs[v].s, vecs[v].addr, vecs[v].be, vecs[v].we, vecs[v].re, vecs[v].wd,
                vecs[v].esel, vecs[v].eswe, vecs[v].evalid, vecs[v].eerr, vecs[v].erd);

    // Back-to-back reads with zero wait states.
    @(posedge clk); #1;
    req_re[0] = 1'b1; req_be[0] = 4'hF; req_addr[0] = 32'h0;
    @(negedge clk);
    check("b2b_wait", rsp_wait[0], 1'b0);
    check("b2b_select0", s_sel[0], 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k < 3) req_addr[0] = 32'(4 * k);
      else idle_req(0);
      @(negedge clk);
      check("b2b_valid", rsp_valid[0], 1'b1);
      check("b2b_rdata", rsp_rdata[0], exp_mem[0][k-1]);
      if (k < 3) check("b2b_address", s_addr[0], 12'(k));
    end
    @(negedge clk);
    check("b2b_valid_end", rsp_valid[0], 1'b0);

    // Abort: request dropped after the first wait cycle.
    @(posedge clk); #1;
    req_re[1] = 1'b1; req_be[1] = 4'hF; req_addr[1] = 32'h24;
    @(negedge clk);
    check("abort_wait_first", rsp_wait[1], 1'b1);
    @(posedge clk); #1;
    idle_req(1);
    @(negedge clk);
    check("abort_wait_dropped", rsp_wait[1], 1'b0);
    check("abort_select", s_sel[1], 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("abort_select_later", s_sel[1], 1'b0);
      check("abort_valid", rsp_valid[1], 1'b0);
      check("abort_error", rsp_err[1], 1'b0);
    end
    do_access(1, 32'h24, 4'hF, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, exp_mem[1][9]);

    // Reset while dut1 is waiting and dut0 is presenting read data.
    @(posedge clk); #1;
    req_re[1] = 1'b1; req_be[1] = 4'hF; req_addr[1] = 32'h28;
    req_re[0] = 1'b1; req_be[0] = 4'hF; req_addr[0] = 32'h10;
    @(posedge clk); #1;
    idle_req(0);
    check("pre_reset_valid", rsp_valid[0], 1'b1);
    check("pre_reset_wait", rsp_wait[1], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_wait", rsp_wait[1], 1'b0);
    check("midreset_valid0", rsp_valid[0], 1'b0);
    check("midreset_rdata0", rsp_rdata[0], 32'h0);
    check("midreset_select1", s_sel[1], 1'b0);
    idle_req(1);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_valid1", rsp_valid[1], 1'b0);
      check("post_reset_select1", s_sel[1], 1'b0);
    end

    // Randomized accesses against the window model.
    for (int n = 0; n < 150; n++) begin
      int          s;
      int          op;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic        re;
      logic [31:0] wd;
      logic        inw;
      s    = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0)
        addr = ($urandom_range(0, 1) == 0) ? (32'h4000 + $urandom_range(0, 32'hFFFF))
                                           : ($urandom | 32'h8000_0000);
      else
        addr = $urandom_range(0, 32'h3FFF);
      be   = 4'($urandom_range(0, 15));
      wd   = $urandom;
      re   = (op != 1);
      we   = (op != 0);
      inw  = (addr < 32'h4000);
      do_access(s, addr, be, we, re, wd, inw, we && !re, re, !inw,
                (re && inw) ? exp_mem[s][(addr >> 2) % DEPTH] : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
